// File: rtl/y_arb_pkg.sv
// Shared types and helpers for the row (Y) round-robin arbiter.
package y_arb_pkg;

  typedef enum logic {
    IDLE  = 1'b0,
    GRANT = 1'b1
  } arb_state_e;

  localparam int unsigned ARB_MAX_WIDTH = 64;
  localparam int unsigned ARB_IDX_W     = $clog2(ARB_MAX_WIDTH);

  // Index of the set bit of a one-hot vector; zero for an all-zero vector.
  function automatic logic [ARB_IDX_W-1:0] rr_onehot2idx(input logic [ARB_MAX_WIDTH-1:0] onehot);
    logic [ARB_IDX_W-1:0] idx;
    idx = '0;
    for (int unsigned i = 0; i < ARB_MAX_WIDTH; i++) begin
      if (onehot[i]) idx = idx | ARB_IDX_W'(i);
    end
    return idx;
  endfunction

endpackage

// File: rtl/rr_priority_pick.sv
// Combinational round-robin pick: first request at or after ptr, wrapping modulo WIDTH.
module rr_priority_pick
  import y_arb_pkg::*;
#(
  parameter int unsigned WIDTH   = 8,
  parameter int unsigned Y_WIDTH = $clog2(WIDTH)
) (
  input  logic [WIDTH-1:0]   req,
  input  logic [Y_WIDTH-1:0] ptr,
  output logic [WIDTH-1:0]   winner,
  output logic [Y_WIDTH-1:0] index,
  output logic               any_valid
);

  logic [2*WIDTH-1:0] dbl_req;
  logic [2*WIDTH-1:0] sel;
  logic               found;

  assign dbl_req = {req, req};

  // Lower copy masked below ptr, upper copy unmasked: a plain low-first
  // priority scan over the doubled vector then yields the rotated order.
  always_comb begin
    sel   = '0;
    found = 1'b0;
    for (int unsigned j = 0; j < 2 * WIDTH; j++) begin
      if (!found && dbl_req[j] && (j >= 32'(ptr))) begin
        sel[j] = 1'b1;
        found  = 1'b1;
      end
    end
  end

  assign winner    = sel[WIDTH-1:0] | sel[2*WIDTH-1:WIDTH];
  assign index     = Y_WIDTH'(rr_onehot2idx(ARB_MAX_WIDTH'(winner)));
  assign any_valid = |req;

endmodule

// File: rtl/y_rr_arbiter_hold.sv
// Row round-robin arbiter with registered grant, valid/ack handshake and bounded burst hold.
module y_rr_arbiter_hold
  import y_arb_pkg::*;
#(
  parameter int unsigned WIDTH    = 8,
  parameter int unsigned Y_WIDTH  = $clog2(WIDTH),
  parameter int unsigned HOLD_MAX = 4
) (
  input  logic               clk_i,
  input  logic               reset_i,
  input  logic               enable_i,
  input  logic [WIDTH-1:0]   req_i,
  input  logic               ack_i,
  output logic [WIDTH-1:0]   gnt_o,
  output logic [Y_WIDTH-1:0] yadd_o,
  output logic               gnt_valid_o
);

  localparam int unsigned HOLD_W = $clog2(HOLD_MAX + 1);

  arb_state_e         state_q, state_n;
  logic [Y_WIDTH-1:0] ptr_q, ptr_n;
  logic [HOLD_W-1:0]  hold_q, hold_n;
  logic [WIDTH-1:0]   gnt_q, gnt_n;
  logic [Y_WIDTH-1:0] yadd_q, yadd_n;

  logic [Y_WIDTH-1:0] after_g;
  logic [Y_WIDTH-1:0] pick_ptr;
  logic [WIDTH-1:0]   pick_onehot;
  logic [Y_WIDTH-1:0] pick_idx;
  logic               pick_any;
  logic               req_g;
  logic               burst_ok;

  assign after_g  = (32'(yadd_q) == WIDTH - 1) ? '0 : yadd_q + Y_WIDTH'(1);
  assign req_g    = req_i[yadd_q];
  assign burst_ok = (32'(hold_q) + 32'd1) < HOLD_MAX;

  // Re-arbitration after a release starts just past the released row, so the
  // single picker serves both the IDLE grant and the no-bubble hand-over.
  assign pick_ptr = (state_q == GRANT) ? after_g : ptr_q;

  rr_priority_pick #(
    .WIDTH   (WIDTH),
    .Y_WIDTH (Y_WIDTH)
  ) u_pick (
    .req       (req_i),
    .ptr       (pick_ptr),
    .winner    (pick_onehot),
    .index     (pick_idx),
    .any_valid (pick_any)
  );

  always_comb begin
    state_n = state_q;
    ptr_n   = ptr_q;
    hold_n  = hold_q;
    gnt_n   = gnt_q;
    yadd_n  = yadd_q;
    unique case (state_q)
      IDLE: begin
        if (enable_i && pick_any) begin
          state_n = GRANT;
          gnt_n   = pick_onehot;
          yadd_n  = pick_idx;
          hold_n  = '0;
        end else begin
          gnt_n  = '0;
          yadd_n = '0;
        end
      end
      GRANT: begin
        if (ack_i && req_g && enable_i && burst_ok) begin
          hold_n = hold_q + HOLD_W'(1);
        end else if (ack_i || !req_g) begin
          ptr_n  = after_g;
          hold_n = '0;
          if (enable_i && pick_any) begin
            gnt_n  = pick_onehot;
            yadd_n = pick_idx;
          end else begin
            state_n = IDLE;
            gnt_n   = '0;
            yadd_n  = '0;
          end
        end
      end
      default: begin
        state_n = IDLE;
        gnt_n   = '0;
        yadd_n  = '0;
      end
    endcase
  end

  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      state_q <= IDLE;
      ptr_q   <= '0;
      hold_q  <= '0;
      gnt_q   <= '0;
      yadd_q  <= '0;
    end else begin
      state_q <= state_n;
      ptr_q   <= ptr_n;
      hold_q  <= hold_n;
      gnt_q   <= gnt_n;
      yadd_q  <= yadd_n;
    end
  end

  assign gnt_o       = gnt_q;
  assign yadd_o      = yadd_q;
  assign gnt_valid_o = (state_q == GRANT);

endmodule

// File: tb/tb_y_rr_arbiter_hold.sv
// Scoreboard bench for y_rr_arbiter_hold: HOLD_MAX=2 main instance, HOLD_MAX=1 second instance.
module tb_y_rr_arbiter_hold;

  logic       clk = 1'b0;
  logic       reset;
  logic       enable;
  logic       ack;
  logic [7:0] req;

  logic [7:0] gnt_a, gnt_b;
  logic [2:0] yadd_a, yadd_b;
  logic       vld_a, vld_b;

  always #5 clk = ~clk;

  y_rr_arbiter_hold #(
    .WIDTH    (8),
    .Y_WIDTH  (3),
    .HOLD_MAX (2)
  ) dut (
    .clk_i       (clk),
    .reset_i     (reset),
    .enable_i    (enable),
    .req_i       (req),
    .ack_i       (ack),
    .gnt_o       (gnt_a),
    .yadd_o      (yadd_a),
    .gnt_valid_o (vld_a)
  );

  y_rr_arbiter_hold #(
    .WIDTH    (8),
    .Y_WIDTH  (3),
    .HOLD_MAX (1)
  ) dut_h1 (
    .clk_i       (clk),
    .reset_i     (reset),
    .enable_i    (enable),
    .req_i       (req),
    .ack_i       (ack),
    .gnt_o       (gnt_b),
    .yadd_o      (yadd_b),
    .gnt_valid_o (vld_b)
  );

  typedef struct {
    bit         use_h1;
    logic [7:0] gnt;
  } exp_t;

  exp_t  sb_q[$];
  string tag_q[$];
  int    n_checks = 0;
  int    n_errors = 0;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  function automatic logic [2:0] idx_of(input logic [7:0] oh);
    logic [2:0] r;
    r = '0;
    for (int i = 0; i < 8; i++) if (oh[i]) r = 3'(i);
    return r;
  endfunction

  // Drive one cycle of stimulus, queue the expected post-edge outputs, then score.
  task automatic step(input string tag, input bit r, input bit e, input logic [7:0] rq,
                      input bit a, input logic [7:0] exp_gnt, input bit use_h1);
    exp_t        ex;
    string       t;
    logic [7:0]  g;
    logic [2:0]  y;
    logic        v;
    reset  = r;
    enable = e;
    req    = rq;
    ack    = a;
    sb_q.push_back('{use_h1, exp_gnt});
    tag_q.push_back(tag);
    @(posedge clk);
    #1;
    ex = sb_q.pop_front();
    t  = tag_q.pop_front();
    g  = ex.use_h1 ? gnt_b  : gnt_a;
    y  = ex.use_h1 ? yadd_b : yadd_a;
    v  = ex.use_h1 ? vld_b  : vld_a;
    check_eq({t, ".gnt"},  32'(g), 32'(ex.gnt));
    check_eq({t, ".yadd"}, 32'(y), 32'(idx_of(ex.gnt)));
    check_eq({t, ".vld"},  32'(v), 32'(|ex.gnt));
  endtask

  initial begin
    logic [7:0] seq [9];
    reset = 1'b1; enable = 1'b0; req = '0; ack = 1'b0;

    step("rst0", 1, 0, 8'h00, 0, 8'h00, 0);
    step("rst1", 1, 1, 8'hFF, 1, 8'h00, 0);

    // Round robin with burst of two per row; wraps 7 -> 0.
    seq = '{8'h01, 8'h01, 8'h02, 8'h02, 8'h10, 8'h10, 8'h80, 8'h80, 8'h01};
    step("rr0", 0, 1, 8'b1001_0011, 0, seq[0], 0);
    for (int i = 1; i < 9; i++) step($sformatf("rr%0d", i), 0, 1, 8'b1001_0011, 1, seq[i], 0);

    // Held grant without ack.
    step("t2rst", 1, 0, 8'h00, 0, 8'h00, 0);
    for (int i = 0; i < 6; i++) step($sformatf("hold%0d", i), 0, 1, 8'b0110_0100, 0, 8'h04, 0);

    // Enable dropped mid-grant, then ack releases to IDLE.
    step("t3rst", 1, 0, 8'h00, 0, 8'h00, 0);
    step("en_g5",   0, 1, 8'h20, 0, 8'h20, 0);
    step("en_hold", 0, 0, 8'h20, 0, 8'h20, 0);
    step("en_ack",  0, 0, 8'h20, 1, 8'h00, 0);
    for (int i = 0; i < 3; i++) step($sformatf("en_off%0d", i), 0, 0, 8'hFF, 0, 8'h00, 0);
    step("idle_ack", 0, 0, 8'hFF, 1, 8'h00, 0);
    step("ptr6",     0, 1, 8'hFF, 0, 8'h40, 0);

    // Withdrawal of the granted row hands over without ack.
    step("t4rst", 1, 0, 8'h00, 0, 8'h00, 0);
    step("wd_g5",   0, 1, 8'h20,        0, 8'h20, 0);
    step("wd_hold", 0, 1, 8'b0110_0000, 0, 8'h20, 0);
    step("wd_g6",   0, 1, 8'b0100_0000, 0, 8'h40, 0);

    // Reset mid-grant returns the pointer to 0.
    step("t5rst", 1, 0, 8'h00, 0, 8'h00, 0);
    step("mr_g3",  0, 1, 8'h08, 0, 8'h08, 0);
    step("mr_hld", 0, 1, 8'h08, 0, 8'h08, 0);
    step("mr_rst", 1, 1, 8'hFF, 0, 8'h00, 0);
    step("mr_g1",  0, 1, 8'b1111_0010, 0, 8'h02, 0);

    // HOLD_MAX=1 instance: single requester re-granted each ack, then idles.
    step("t6rst", 1, 0, 8'h00, 0, 8'h00, 1);
    step("h1_g0", 0, 1, 8'h01, 0, 8'h01, 1);
    for (int i = 0; i < 4; i++) step($sformatf("h1_re%0d", i), 0, 1, 8'h01, 1, 8'h01, 1);
    step("h1_idle", 0, 1, 8'h00, 0, 8'h00, 1);
    step("h1_stay", 0, 1, 8'h00, 1, 8'h00, 1);

    check_eq("sb_empty", 32'(sb_q.size()), 32'd0);
    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
